// File: rtl/prog_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_pkg
//  Description : Shared opcode header for the lab CPU: instruction/argument
//                widths, opcode and register constants, NOP encoding and the
//                program-memory FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_mem_pkg;

   localparam int unsigned INSTRUCTION_WIDTH = 16;
   localparam int unsigned ARG_WIDTH         = 8;
   localparam int unsigned OPCODE_WIDTH      = 4;
   localparam int unsigned REG_WIDTH         = 4;

   // Opcodes (upper nibble of the instruction word)
   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 4'h0;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 4'h1;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 4'h2;
   localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 4'h3;
   localparam logic [OPCODE_WIDTH-1:0] OP_OR    = 4'h4;
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 4'h5;
   localparam logic [OPCODE_WIDTH-1:0] OP_JZ    = 4'h6;
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 4'h7;
   localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 4'hF;

   // Register selectors
   localparam logic [REG_WIDTH-1:0] R0 = 4'd0;
   localparam logic [REG_WIDTH-1:0] R1 = 4'd1;
   localparam logic [REG_WIDTH-1:0] R2 = 4'd2;
   localparam logic [REG_WIDTH-1:0] R3 = 4'd3;

   // Assemble one instruction word from its fields
   function automatic logic [INSTRUCTION_WIDTH-1:0] make_instr(
      input logic [OPCODE_WIDTH-1:0] op,
      input logic [REG_WIDTH-1:0]    rd,
      input logic [ARG_WIDTH-1:0]    arg
   );
      return {op, rd, arg};
   endfunction

   // NOP is deliberately non-zero so a cleared memory is distinguishable
   // from an uninitialised or zeroed one.
   localparam logic [INSTRUCTION_WIDTH-1:0] NOP = {OP_NOP, R0, 8'h00};

   // Program-memory controller states
   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;

endpackage : prog_mem_pkg
`default_nettype wire

// File: rtl/prog_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_array
//  Description : Single-port synchronous RAM with registered read data.
//                Addresses at or beyond DEPTH are not written and read back
//                as RESET_WORD.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_array #(
   parameter int unsigned       INSTR_W    = 16,
   parameter int unsigned       ADDR_W     = 8,
   parameter int unsigned       DEPTH      = 32,
   parameter logic [INSTR_W-1:0] RESET_WORD = '0
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               we_i,
   input  logic               re_i,
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [INSTR_W-1:0] wdata_i,
   output logic [INSTR_W-1:0] rdata_o
);

   localparam int unsigned    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [INSTR_W-1:0] rdata_q;
   logic [IDX_W-1:0]   idx;
   logic               in_range;

   assign idx      = addr_i[IDX_W-1:0];
   assign in_range = ({1'b0, addr_i} < DEPTH_C);
   assign rdata_o  = rdata_q;

   // Storage array: written only for in-range addresses, never reset
   always_ff @(posedge clk_i) begin
      if (we_i && in_range) begin
         mem_q[idx] <= wdata_i;
      end
   end

   // Registered read port; out-of-range reads return the fill word
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= RESET_WORD;
      end else if (re_i) begin
         rdata_q <= in_range ? mem_q[idx] : RESET_WORD;
      end
   end

endmodule : prog_mem_array
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem
//  Description : Writable program memory for the lab CPU. Clears itself to
//                NOP after reset, accepts program bursts over a valid/ready
//                loader port and serves 1-cycle-latency instruction fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_mem
   import prog_mem_pkg::*;
#(
   parameter int unsigned        INSTR_W   = INSTRUCTION_WIDTH,
   parameter int unsigned        ADDR_W    = ARG_WIDTH,
   parameter int unsigned        DEPTH     = 32,
   parameter logic [INSTR_W-1:0] FILL_WORD = INSTR_W'(NOP)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   // Fetch port
   input  logic               fetch_en_i,
   input  logic [ADDR_W-1:0]  fetch_addr_i,
   output logic [INSTR_W-1:0] fetch_data_o,
   output logic               fetch_valid_o,
   output logic               busy_o,
   // Loader port
   input  logic               load_start_i,
   input  logic [ADDR_W-1:0]  load_base_i,
   input  logic [ADDR_W:0]    load_len_i,
   input  logic               load_valid_i,
   input  logic [INSTR_W-1:0] load_data_i,
   output logic               load_ready_o,
   output logic               load_done_o,
   output logic               load_err_o
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W+1:0] DEPTH_W2 = (ADDR_W+2)'(DEPTH);

   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  clear_ptr_q, clear_ptr_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [ADDR_W:0]    last_q, last_d;
   logic [ADDR_W:0]    cnt_q, cnt_d;
   logic               fetch_valid_q, fetch_valid_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               mem_we;
   logic               mem_re;
   logic [ADDR_W-1:0]  mem_addr;
   logic [INSTR_W-1:0] mem_wdata;
   logic [ADDR_W-1:0]  wr_addr;
   logic [ADDR_W+1:0]  range_end;

   // base+cnt never exceeds DEPTH-1 once a burst is accepted, so the low
   // ADDR_W bits of the counter are enough to form the write address.
   assign wr_addr   = base_q + cnt_q[ADDR_W-1:0];
   // Widened by two bits so base+len cannot wrap before the range check.
   assign range_end = (ADDR_W+2)'(load_base_i) + (ADDR_W+2)'(load_len_i);

   assign busy_o        = (state_q != ST_IDLE);
   assign load_ready_o  = (state_q == ST_LOAD);
   assign fetch_valid_o = fetch_valid_q;
   assign load_done_o   = done_q;
   assign load_err_o    = err_q;

   // Next-state logic: clear sweep, fetch/load arbitration and burst counting
   always_comb begin
      state_d       = state_q;
      clear_ptr_d   = clear_ptr_q;
      base_d        = base_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      fetch_valid_d = 1'b0;
      done_d        = 1'b0;
      err_d         = 1'b0;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
      mem_addr      = fetch_addr_i;
      mem_wdata     = load_data_i;

      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_addr  = clear_ptr_q;
            mem_wdata = FILL_WORD;
            if (clear_ptr_q == LAST_IDX) begin
               state_d     = ST_IDLE;
               clear_ptr_d = '0;
            end else begin
               clear_ptr_d = clear_ptr_q + 1'b1;
            end
         end

         ST_IDLE: begin
            // A fetch on the same edge as load_start still reads old contents:
            // nothing is written until the LOAD state.
            if (fetch_en_i) begin
               mem_re        = 1'b1;
               fetch_valid_d = 1'b1;
            end
            if (load_start_i) begin
               if (load_len_i == '0) begin
                  done_d = 1'b1;
               end else if (range_end > DEPTH_W2) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_LOAD;
                  base_d  = load_base_i;
                  last_d  = load_len_i - 1'b1;
                  cnt_d   = '0;
               end
            end
         end

         ST_LOAD: begin
            mem_addr = wr_addr;
            if (load_valid_i) begin
               mem_we = 1'b1;
               if (cnt_q == last_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d     = ST_CLEAR;
            clear_ptr_d = '0;
         end
      endcase
   end

   // Controller registers; reset restarts the clear sweep and drops pulses
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_CLEAR;
         clear_ptr_q   <= '0;
         base_q        <= '0;
         last_q        <= '0;
         cnt_q         <= '0;
         fetch_valid_q <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         clear_ptr_q   <= clear_ptr_d;
         base_q        <= base_d;
         last_q        <= last_d;
         cnt_q         <= cnt_d;
         fetch_valid_q <= fetch_valid_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   prog_mem_array #(
      .INSTR_W    (INSTR_W),
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .RESET_WORD (FILL_WORD)
   ) u_array (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .rdata_o (fetch_data_o)
   );

endmodule : prog_mem
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_mem
//  Description : Directed self-checking bench for prog_mem (DEPTH=32,
//                16-bit words, 8-bit addresses, NOP = 16'hF000).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned DEPTH   = 32;
   localparam logic [15:0] NOPW    = 16'hF000;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               fetch_en;
   logic [ADDR_W-1:0]  fetch_addr;
   logic [INSTR_W-1:0] fetch_data;
   logic               fetch_valid;
   logic               busy;
   logic               load_start;
   logic [ADDR_W-1:0]  load_base;
   logic [ADDR_W:0]    load_len;
   logic               load_valid;
   logic [INSTR_W-1:0] load_data;
   logic               load_ready;
   logic               load_done;
   logic               load_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   prog_mem #(
      .INSTR_W   (INSTR_W),
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .FILL_WORD (NOPW)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .fetch_en_i    (fetch_en),
      .fetch_addr_i  (fetch_addr),
      .fetch_data_o  (fetch_data),
      .fetch_valid_o (fetch_valid),
      .busy_o        (busy),
      .load_start_i  (load_start),
      .load_base_i   (load_base),
      .load_len_i    (load_len),
      .load_valid_i  (load_valid),
      .load_data_i   (load_data),
      .load_ready_o  (load_ready),
      .load_done_o   (load_done),
      .load_err_o    (load_err)
   );

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single fetch: request on one edge, result visible after it
   task automatic fetch(input logic [ADDR_W-1:0] a, input logic [15:0] exp, input string tag);
      fetch_en   = 1'b1;
      fetch_addr = a;
      tick();
      fetch_en = 1'b0;
      chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
      chk({tag, "_data"}, {16'd0, fetch_data}, {16'd0, exp});
   endtask

   task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
      load_start = 1'b1;
      load_base  = b;
      load_len   = l;
      tick();
      load_start = 1'b0;
   endtask

   // Count busy cycles after reset release, bounded
   task automatic wait_clear(input string tag, output logic saw_done);
      int n;
      n = 0;
      saw_done = 1'b0;
      while (busy && n < 100) begin
         tick();
         n++;
         if (load_done || load_err) saw_done = 1'b1;
      end
      chk(tag, n, DEPTH);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic sd;
      rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
      load_start = 1'b0; load_base = '0; load_len = '0;
      load_valid = 1'b0; load_data = '0;

      // ---- Reset values ----
      tick(); tick();
      chk("rst_busy",  {31'd0, busy}, 32'd1);
      chk("rst_data",  {16'd0, fetch_data}, {16'd0, NOPW});
      chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_ready", {31'd0, load_ready}, 32'd0);
      chk("rst_done",  {31'd0, load_done}, 32'd0);
      chk("rst_err",   {31'd0, load_err}, 32'd0);

      // ---- 1. Clear takes DEPTH cycles, everything reads NOP ----
      rst_n = 1'b1;
      wait_clear("clear_cycles", sd);
      for (int a = 0; a < 32; a++) fetch(ADDR_W'(a), NOPW, "clr_fetch");
      tick();
      chk("idle_valid_low", {31'd0, fetch_valid}, 32'd0);
      chk("idle_data_hold", {16'd0, fetch_data}, {16'd0, NOPW});

      // ---- 2. Burst base=4 len=3 with gaps ----
      start_load(8'd4, 9'd3);
      chk("ld2_busy",  {31'd0, busy}, 32'd1);
      chk("ld2_ready", {31'd0, load_ready}, 32'd1);
      load_valid = 1'b1; load_data = 16'h00A1; tick(); load_valid = 1'b0;
      chk("ld2_b1_done", {31'd0, load_done}, 32'd0);
      tick();
      load_valid = 1'b1; load_data = 16'h00B2; tick(); load_valid = 1'b0;
      chk("ld2_b2_done", {31'd0, load_done}, 32'd0);
      tick();
      load_valid = 1'b1; load_data = 16'h00C3; tick(); load_valid = 1'b0;
      chk("ld2_done",       {31'd0, load_done}, 32'd1);
      chk("ld2_done_ready", {31'd0, load_ready}, 32'd0);
      chk("ld2_done_busy",  {31'd0, busy}, 32'd0);
      tick();
      chk("ld2_done_pulse", {31'd0, load_done}, 32'd0);
      fetch(8'd4, 16'h00A1, "f4");
      fetch(8'd5, 16'h00B2, "f5");
      fetch(8'd6, 16'h00C3, "f6");
      fetch(8'd7, NOPW, "f7");

      // ---- 3. Out-of-range burst ----
      start_load(8'd30, 9'd3);
      chk("err_pulse", {31'd0, load_err}, 32'd1);
      chk("err_done",  {31'd0, load_done}, 32'd0);
      chk("err_busy",  {31'd0, busy}, 32'd0);
      chk("err_ready", {31'd0, load_ready}, 32'd0);
      tick();
      chk("err_pulse_end", {31'd0, load_err}, 32'd0);
      chk("err_busy2",     {31'd0, busy}, 32'd0);
      fetch(8'd30, NOPW, "f30");

      // ---- 4. Zero-length and full-depth bursts ----
      start_load(8'd0, 9'd0);
      chk("len0_done", {31'd0, load_done}, 32'd1);
      chk("len0_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("len0_pulse_end", {31'd0, load_done}, 32'd0);
      start_load(8'd0, 9'd32);
      for (int i = 0; i < 32; i++) begin
         load_valid = 1'b1;
         load_data  = 16'h1000 + 16'(i);
         tick();
         if (i < 31) chk("full_no_done", {31'd0, load_done}, 32'd0);
      end
      load_valid = 1'b0;
      chk("full_done", {31'd0, load_done}, 32'd1);
      tick();
      fetch(8'd0,  16'h1000, "full0");
      fetch(8'd17, 16'h1011, "full17");
      fetch(8'd31, 16'h101F, "full31");
      fetch(8'd32, NOPW, "oor32");
      fetch(8'd200, NOPW, "oor200");

      // ---- 5. Fetch and second start ignored during LOAD ----
      start_load(8'd10, 9'd2);
      fetch_en = 1'b1; fetch_addr = 8'd10;
      load_start = 1'b1; load_base = 8'd0; load_len = 9'd1;
      tick();
      chk("ld5_fv0", {31'd0, fetch_valid}, 32'd0);
      chk("ld5_busy", {31'd0, busy}, 32'd1);
      load_valid = 1'b1; load_data = 16'h2A2A; tick();
      load_start = 1'b0;
      chk("ld5_fv1", {31'd0, fetch_valid}, 32'd0);
      chk("ld5_no_early_done", {31'd0, load_done}, 32'd0);
      load_data = 16'h2B2B; tick();
      load_valid = 1'b0; fetch_en = 1'b0;
      chk("ld5_done", {31'd0, load_done}, 32'd1);
      tick();
      fetch(8'd10, 16'h2A2A, "f10");
      fetch(8'd11, 16'h2B2B, "f11");
      fetch(8'd0,  16'h1000, "f0_untouched");

      // Same-edge fetch and load_start: fetch sees old word
      fetch_en = 1'b1; fetch_addr = 8'd10;
      load_start = 1'b1; load_base = 8'd10; load_len = 9'd1;
      tick();
      fetch_en = 1'b0; load_start = 1'b0;
      chk("same_fv",   {31'd0, fetch_valid}, 32'd1);
      chk("same_data", {16'd0, fetch_data}, 32'h2A2A);
      chk("same_busy", {31'd0, busy}, 32'd1);
      load_valid = 1'b1; load_data = 16'h3B3B; tick(); load_valid = 1'b0;
      chk("same_done", {31'd0, load_done}, 32'd1);
      fetch(8'd10, 16'h3B3B, "f10_new");

      // ---- 6. Reset mid-LOAD ----
      start_load(8'd8, 9'd4);
      load_valid = 1'b1;
      load_data = 16'h4444; tick();
      load_data = 16'h5555; tick();
      load_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_busy",  {31'd0, busy}, 32'd1);
      chk("mid_ready", {31'd0, load_ready}, 32'd0);
      chk("mid_data",  {16'd0, fetch_data}, {16'd0, NOPW});
      chk("mid_done",  {31'd0, load_done}, 32'd0);
      tick();
      rst_n = 1'b1;
      wait_clear("reclear_cycles", sd);
      chk("reclear_no_pulse", {31'd0, sd}, 32'd0);
      fetch(8'd8,  NOPW, "rc8");
      fetch(8'd9,  NOPW, "rc9");
      fetch(8'd10, NOPW, "rc10");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_prog_mem
`default_nettype wire
